// File: rtl/sm_regdump.sv
// sm_regdump: debug-port register dumper for the schoolMIPS core.
//
// On a start pulse the block sweeps debug register addresses FIRST_REG..LAST_REG.
// For each address it captures the 32-bit value returned on regData and emits
// it as a byte stream, MSB byte first.
//
// Ports:
//   clk      in   1   system clock
//   rst_n    in   1   synchronous active-low reset
//   start    in   1   single-cycle sweep request (ignored unless idle)
//   busy     out  1   high from the cycle after an accepted start until done
//   done     out  1   single-cycle pulse after the last byte is accepted
//   regAddr  out  5   debug register address to the core
//   regData  in  32   debug register data (combinational on regAddr)
//   tx_valid out  1   byte available on tx_data
//   tx_data  out  8   output byte
//   tx_ready in   1   downstream accepts a byte when high together with tx_valid
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid is raised, it and tx_data hold steady until that transfer.
// Only reset can break this rule.
//
// Optional feature macro: SM_REGDUMP_HEADER_EN.
// When defined, each record is preceded by a header byte {3'b101, regAddr}.
module sm_regdump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  generate
    if (FIRST_REG > LAST_REG) begin : g_bad_range
      $error("sm_regdump: FIRST_REG must not exceed LAST_REG");
    end
  endgenerate

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);
`ifdef SM_REGDUMP_HEADER_EN
  localparam logic [2:0] LAST_BYTE  = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE  = 3'd3;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, CAPTURE, SEND, FINISH} state_t;

  state_t      state, stateNext;
  logic [4:0]  regAddrNext;
  logic        busyNext, doneNext, validNext;
  logic [31:0] shiftReg, shiftNext;
  logic [2:0]  byteCnt, cntNext;
  logic        accept;

  assign accept = tx_valid & tx_ready;

  // The header byte is taken straight from regAddr. Gating it with SEND
  // keeps tx_data at zero while idle.
`ifdef SM_REGDUMP_HEADER_EN
  assign tx_data = (state == SEND && byteCnt == 3'd0) ? {3'b101, regAddr}
                                                      : shiftReg[31:24];
`else
  assign tx_data = shiftReg[31:24];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      regAddr  <= FIRST_ADDR;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      shiftReg <= 32'h0;
      byteCnt  <= 3'd0;
    end else begin
      state    <= stateNext;
      regAddr  <= regAddrNext;
      busy     <= busyNext;
      done     <= doneNext;
      tx_valid <= validNext;
      shiftReg <= shiftNext;
      byteCnt  <= cntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    regAddrNext = regAddr;
    busyNext    = busy;
    doneNext    = 1'b0;
    validNext   = tx_valid;
    shiftNext   = shiftReg;
    cntNext     = byteCnt;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext   = SETUP;
          regAddrNext = FIRST_ADDR;
          busyNext    = 1'b1;
        end
      end
      // regAddr is held for one cycle so the core's register-file read path
      // settles before regData is captured.
      SETUP: stateNext = CAPTURE;
      CAPTURE: begin
        shiftNext = regData;
        cntNext   = 3'd0;
        validNext = 1'b1;
        stateNext = SEND;
      end
      SEND: begin
        if (accept) begin
`ifdef SM_REGDUMP_HEADER_EN
          // The header byte does not consume data, so the shift waits for it.
          if (byteCnt != 3'd0) shiftNext = {shiftReg[23:0], 8'h00};
`else
          shiftNext = {shiftReg[23:0], 8'h00};
`endif
          cntNext = byteCnt + 3'd1;
          if (byteCnt == LAST_BYTE) begin
            validNext = 1'b0;
            // The range check comes before the increment, so regAddr never wraps.
            if (regAddr == LAST_ADDR) begin
              stateNext = FINISH;
              doneNext  = 1'b1;
            end else begin
              regAddrNext = regAddr + 5'd1;
              stateNext   = SETUP;
            end
          end
        end
      end
      FINISH: begin
        busyNext    = 1'b0;
        regAddrNext = FIRST_ADDR;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm_regdump.sv
// Testbench for sm_regdump.
// Instance A sweeps registers 0..31, instance B reads register 5 only, and
// instance C reads register 3 only.
module tb_sm_regdump;

`ifdef SM_REGDUMP_HEADER_EN
  localparam int BPR = 5;
`else
  localparam int BPR = 4;
`endif
  localparam int DONE_CYC_A = 1 + 32 * (BPR + 2) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] rf [32];

  logic startA, busyA, doneA, validA, readyA;
  logic [4:0] addrA; logic [31:0] dataA; logic [7:0] txA;
  logic startB, busyB, doneB, validB, readyB;
  logic [4:0] addrB; logic [31:0] dataB; logic [7:0] txB;
  logic startC, busyC, doneC, validC, readyC;
  logic [4:0] addrC; logic [31:0] dataC; logic [7:0] txC;

  assign dataA = rf[addrA];
  assign dataB = rf[addrB];
  assign dataC = rf[addrC];

  sm_regdump #(.FIRST_REG(0), .LAST_REG(31)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .busy(busyA), .done(doneA),
    .regAddr(addrA), .regData(dataA), .tx_valid(validA), .tx_data(txA), .tx_ready(readyA));
  sm_regdump #(.FIRST_REG(5), .LAST_REG(5)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .busy(busyB), .done(doneB),
    .regAddr(addrB), .regData(dataB), .tx_valid(validB), .tx_data(txB), .tx_ready(readyB));
  sm_regdump #(.FIRST_REG(3), .LAST_REG(3)) dutC (
    .clk(clk), .rst_n(rst_n), .start(startC), .busy(busyC), .done(doneC),
    .regAddr(addrC), .regData(dataC), .tx_valid(validC), .tx_data(txC), .tx_ready(readyC));

  int nVec = 0;
  int nMis = 0;
  int doneCntA = 0, doneCntB = 0;
  logic [7:0] expA_q[$];
  logic [7:0] expB_q[$];
  logic [7:0] expC_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: bytes are sampled on the falling edge, where the handshake is stable.
  always @(negedge clk) begin
    if (doneA) doneCntA++;
    if (doneB) doneCntB++;
    if (validA && readyA) begin
      if (expA_q.size() == 0) check_eq("A_extra_byte", {24'h0, txA}, 32'hFFFF_FFFF);
      else check_eq("A_byte", {24'h0, txA}, {24'h0, expA_q.pop_front()});
    end
    if (validB && readyB) begin
      if (expB_q.size() == 0) check_eq("B_extra_byte", {24'h0, txB}, 32'hFFFF_FFFF);
      else check_eq("B_byte", {24'h0, txB}, {24'h0, expB_q.pop_front()});
    end
    if (validC && readyC) begin
      if (expC_q.size() == 0) check_eq("C_extra_byte", {24'h0, txC}, 32'hFFFF_FFFF);
      else check_eq("C_byte", {24'h0, txC}, {24'h0, expC_q.pop_front()});
    end
  end

  task automatic push_rec(input logic [4:0] a, input logic [31:0] v, input bit toA);
`ifdef SM_REGDUMP_HEADER_EN
    if (toA) expA_q.push_back({3'b101, a}); else expB_q.push_back({3'b101, a});
`endif
    for (int k = 3; k >= 0; k--) begin
      if (toA) expA_q.push_back(v[8*k +: 8]); else expB_q.push_back(v[8*k +: 8]);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_startB();
    startB = 1'b1; tick(); startB = 1'b0;
  endtask

  task automatic wait_doneB(input string tag);
    int i;
    i = 0;
    while (!doneB && i < 300) begin tick(); i++; end
    check_eq(tag, {31'h0, doneB}, 32'h1);
  endtask

  task automatic wait_validB(input string tag);
    int i;
    i = 0;
    while (!validB && i < 50) begin tick(); i++; end
    check_eq(tag, {31'h0, validB}, 32'h1);
  endtask

  initial begin
    int cyc, nb, base;
    logic [7:0] held;
    rst_n = 1'b0;
    startA = 0; startB = 0; startC = 0;
    readyA = 0; readyB = 0; readyC = 0;
    for (int i = 0; i < 32; i++) rf[i] = (32'h0101_0101 * i) ^ 32'h5A00_00C3;
    rf[0] = 32'h0040_0010;  // PC
    repeat (3) tick();

    // Reset state
    check_eq("rst_busy", {31'h0, busyA}, 32'h0);
    check_eq("rst_done", {31'h0, doneA}, 32'h0);
    check_eq("rst_valid", {31'h0, validA}, 32'h0);
    check_eq("rst_txdata", {24'h0, txA}, 32'h0);
    check_eq("rst_addrB", {27'h0, addrB}, 32'h5);
    rst_n = 1'b1;
    tick();

    // Full sweep 0..31 with tx_ready high
    for (int r = 0; r < 32; r++) push_rec(5'(r), rf[r], 1'b1);
    readyA = 1'b1;
    startA = 1'b1; tick(); startA = 1'b0;
    cyc = 2; nb = 0;
    while (!doneA && cyc < 400) begin
      check_eq("A_busy", {31'h0, busyA}, 32'h1);
      if (validA) begin
        check_eq("A_addr", {27'h0, addrA}, nb / BPR);
        nb++;
      end
      tick(); cyc++;
    end
    check_eq("A_done_cycle", cyc, DONE_CYC_A);
    check_eq("A_bytes", nb, 32 * BPR);
    tick();
    check_eq("A_done_pulse", {31'h0, doneA}, 32'h0);
    check_eq("A_busy_after", {31'h0, busyA}, 32'h0);
    check_eq("A_addr_after", {27'h0, addrA}, 32'h0);
    check_eq("A_done_count", doneCntA, 1);
    check_eq("A_q_empty", expA_q.size(), 0);

    // Single register 5 = 12345678
    rf[5] = 32'h1234_5678;
`ifdef SM_REGDUMP_HEADER_EN
    expB_q.push_back(8'hA5);
`endif
    expB_q.push_back(8'h12); expB_q.push_back(8'h34);
    expB_q.push_back(8'h56); expB_q.push_back(8'h78);
    readyB = 1'b1;
    pulse_startB();
    wait_doneB("B_done_t2");
    tick();
    check_eq("B_q_empty_t2", expB_q.size(), 0);

    // Backpressure: three stalled cycles per byte
    rf[5] = 32'hA1B2_C3D4;
`ifdef SM_REGDUMP_HEADER_EN
    expB_q.push_back(8'hA5);
`endif
    expB_q.push_back(8'hA1); expB_q.push_back(8'hB2);
    expB_q.push_back(8'hC3); expB_q.push_back(8'hD4);
    readyB = 1'b0;
    pulse_startB();
    for (int b = 0; b < BPR; b++) begin
      wait_validB("B_valid_t3");
      held = txB;
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        check_eq("B_stall_valid", {31'h0, validB}, 32'h1);
        check_eq("B_stall_data", {24'h0, txB}, {24'h0, held});
        tick();
      end
      readyB = 1'b1; tick(); readyB = 1'b0;
    end
    wait_doneB("B_done_t3");
    tick();
    check_eq("B_q_empty_t3", expB_q.size(), 0);

    // Start re-pulsed mid-sweep and in the FINISH cycle
    base = doneCntB;
    rf[5] = 32'h0BAD_F00D;
    push_rec(5'd5, rf[5], 1'b0);
    readyB = 1'b1;
    pulse_startB();
    wait_validB("B_valid_t4");
    pulse_startB();
    wait_doneB("B_done_t4");
    pulse_startB();
    check_eq("B_finish_start_ignored", {31'h0, busyB}, 32'h0);
    tick();
    check_eq("B_not_queued", {31'h0, busyB}, 32'h0);
    check_eq("B_one_done", doneCntB - base, 1);
    check_eq("B_q_empty_t4", expB_q.size(), 0);
    push_rec(5'd5, rf[5], 1'b0);
    pulse_startB();
    wait_doneB("B_done_t4b");
    tick();
    check_eq("B_second_done", doneCntB - base, 2);

    // Reset during SEND with the byte stalled
    base = doneCntB;
    rf[5] = 32'hCAFE_0123;
    push_rec(5'd5, rf[5], 1'b0);
    readyB = 1'b0;
    pulse_startB();
    wait_validB("B_valid_t5");
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid_valid", {31'h0, validB}, 32'h0);
    check_eq("rst_mid_busy", {31'h0, busyB}, 32'h0);
    check_eq("rst_mid_addr", {27'h0, addrB}, 32'h5);
    check_eq("rst_mid_done", {31'h0, doneB}, 32'h0);
    rst_n = 1'b1;
    expB_q.delete();
    tick();
    check_eq("rst_no_done", doneCntB - base, 0);
    push_rec(5'd5, rf[5], 1'b0);
    readyB = 1'b1;
    pulse_startB();
    wait_doneB("B_done_t5");
    tick();
    check_eq("B_q_empty_t5", expB_q.size(), 0);

`ifdef SM_REGDUMP_HEADER_EN
    // Header record for register 3
    rf[3] = 32'hDEAD_BEEF;
    expC_q.push_back(8'hA3); expC_q.push_back(8'hDE); expC_q.push_back(8'hAD);
    expC_q.push_back(8'hBE); expC_q.push_back(8'hEF);
    readyC = 1'b1;
    startC = 1'b1; tick(); startC = 1'b0;
    cyc = 0;
    while (!doneC && cyc < 50) begin tick(); cyc++; end
    check_eq("C_done", {31'h0, doneC}, 32'h1);
    tick();
    check_eq("C_q_empty", expC_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/sm_regdump.md
Name: sm_regdump

Overview:
- Debug-port reader for the schoolMIPS core. It drives the core's debug register address (`regAddr`) and captures the returned debug data (`regData`).
- On a start pulse it sweeps a register range and emits each 32-bit value as a byte stream over a valid/ready handshake.
- The byte stream feeds a UART transmitter or a host link.
- Register address 0 returns the PC by core convention; the block passes it through like any other register.

Parameters:
- FIRST_REG, 0, first debug register address in the sweep (0..31).
- LAST_REG, 31, last debug register address in the sweep (FIRST_REG..31).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to begin a sweep
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse after the last byte is accepted
- regAddr  out  5  debug register address to the core
- regData  in  32  debug register data from the core (combinational on regAddr)
- tx_valid  out  1  byte available on tx_data
- tx_data  out  8  output byte
- tx_ready  in  1  downstream accepts a byte when high with tx_valid

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low, sampled on the rising edge of `clk`.
- Reset values: state=IDLE, regAddr=FIRST_REG, busy=0, done=0, tx_valid=0, tx_data=0, internal byte counter=0, shift register=0.
- Reset mid-sweep: everything returns to the reset values on the next edge. tx_valid drops even if the current byte has not been accepted. No done pulse.
- States: IDLE, SETUP, CAPTURE, SEND, FINISH.
- IDLE:
  - start=1 → SETUP, regAddr←FIRST_REG, busy←1.
  - start=0 → stay in IDLE.
- SETUP (1 cycle): regAddr is stable; this gives the core's register-file read path one full cycle to settle. → CAPTURE.
- CAPTURE (1 cycle): shift register←regData, byte counter←0. → SEND.
  - Each register value is a per-register snapshot, not atomic across the sweep; the core keeps running.
- SEND:
  - tx_valid=1; tx_data = shift register [31:24] (big-endian, MSB byte first).
  - On tx_valid&tx_ready: shift register shifts left by 8, counter increments.
  - After the 4th accepted byte (counter 3 with handshake):
    - if regAddr==LAST_REG → FINISH, tx_valid←0;
    - else regAddr←regAddr+1 → SETUP, tx_valid←0.
  - tx_valid, once asserted, must not deassert and tx_data must not change until the byte is accepted (except on reset).
  - Between records tx_valid is low for at least 2 cycles (SETUP, CAPTURE).
- FINISH (1 cycle): done=1, busy←0, regAddr←FIRST_REG. → IDLE.
- start while busy (any state other than IDLE) is ignored. It is not queued.
- start asserted in the FINISH cycle is ignored; start in the following IDLE cycle is accepted.
- regAddr arithmetic is 5-bit. With LAST_REG≤31 it never wraps, because the range check occurs before the increment.
- Elaboration: FIRST_REG>LAST_REG is illegal. The block flags it with a generate-time $error.
- Total bytes per sweep: 4×(LAST_REG−FIRST_REG+1). With tx_ready tied high, cycles from start to done = 1+(LAST_REG−FIRST_REG+1)×6+1.

Optional Feature:
- SM_REGDUMP_HEADER_EN.
- Defined:
  - Each record is 5 bytes: header byte {3'b101, regAddr[4:0]} is sent first, then the 4 data bytes MSB first.
  - The header uses the same valid/ready rules. The byte counter runs 0..4.
  - Cycle count per record with tx_ready high becomes 7.
- Undefined: 4 bytes per record, no header, as described above.

Test Plan:
1. tx_ready=1, FIRST_REG=0, LAST_REG=31, start pulse:
   - regAddr steps 0..31;
   - 128 bytes emitted; bytes 0–3 equal the PC in MSB-first order;
   - done pulses exactly once, at cycle 194 after start; busy is high for exactly the intervening cycles.
2. Register 5 preloaded to 32'h12345678, FIRST_REG=LAST_REG=5, tx_ready=1 → bytes 8'h12, 8'h34, 8'h56, 8'h78, then done.
3. Backpressure on FIRST_REG=LAST_REG=5, value 32'hA1B2C3D4: tx_ready low for 3 cycles on each byte → tx_valid stays high and tx_data is held stable while stalled (8'hA1 for 3 cycles, etc.); sequence completes unchanged.
4. start re-pulsed mid-sweep and in the FINISH cycle → ignored; exactly one done pulse; a subsequent start after IDLE begins a fresh sweep.
5. rst_n=0 during SEND with tx_valid=1 and tx_ready=0 → next edge: tx_valid=0, busy=0, regAddr=FIRST_REG, no done pulse; a fresh start afterwards works normally.
6. SM_REGDUMP_HEADER_EN defined, register 3 preloaded to 32'hDEADBEEF, FIRST_REG=LAST_REG=3 → bytes 8'hA3, 8'hDE, 8'hAD, 8'hBE, 8'hEF.
